// File: rtl/mult_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl_pkg
// Shared definitions for the sequenced wide multiplier: the width of one
// operand chunk (the native width of the small array multiplier), the
// controller state encoding and a helper for the chunk count.
// ---------------------------------------------------------------------------
package mult_seq_ctrl_pkg;

   // Width of one operand chunk, fixed by the 3x3 multiplier being shared.
   localparam int CHUNK = 3;

   // Controller state encoding.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      RUN  = S_RUN,
      DONE = S_DONE
   } state_t;

   // Number of chunks an operand of the given width splits into.
   function automatic int chunkCount(input int width);
      return width / CHUNK;
   endfunction

endpackage

// File: rtl/mult_seq_ctrl_mul3.sv
// ---------------------------------------------------------------------------
// multiplier_3bit
// Purely combinational 3x3 unsigned array multiplier. This is the single
// shared arithmetic resource that mult_seq_ctrl time-multiplexes.
//
// Ports:
//   i_a  [2:0]  multiplicand chunk
//   i_b  [2:0]  multiplier chunk
//   o_p  [5:0]  unsigned product i_a * i_b
// ---------------------------------------------------------------------------
module multiplier_3bit
   import mult_seq_ctrl_pkg::*;
(
   input  logic [CHUNK-1:0]   i_a,
   input  logic [CHUNK-1:0]   i_b,
   output logic [2*CHUNK-1:0] o_p
);

   logic [2*CHUNK-1:0] w_row0;
   logic [2*CHUNK-1:0] w_row1;
   logic [2*CHUNK-1:0] w_row2;

   // Each row of the array is the multiplicand gated by one multiplier bit,
   // widened to the product width before being weighted by its bit position.
   assign w_row0 = {3'b000, i_a & {3{i_b[0]}}};
   assign w_row1 = {3'b000, i_a & {3{i_b[1]}}} << 1;
   assign w_row2 = {3'b000, i_a & {3{i_b[2]}}} << 2;

   // Summing the weighted rows gives the full product; 7*7=49 fits in 6 bits.
   assign o_p = w_row0 + w_row1 + w_row2;

endmodule

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
// Computes an OPW x OPW unsigned product by walking every pair of 3-bit
// operand chunks through one shared 3x3 multiplier, shifting each partial
// product into place and accumulating it. One chunk pair per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   controller can accept operands (only in IDLE)
//   in_a       multiplicand, unsigned, OPW bits
//   in_b       multiplier, unsigned, OPW bits
//   out_valid  product valid (DONE)
//   out_ready  consumer accepts product
//   product    unsigned product, 2*OPW bits, held stable while in DONE
//   busy       high in RUN or DONE
// ---------------------------------------------------------------------------
module mult_seq_ctrl
   import mult_seq_ctrl_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int STEP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   in_a,
   input  logic [OPW-1:0]   in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*OPW-1:0] product,
   output logic             busy
);

   localparam int K         = chunkCount(OPW);
   localparam int LAST_STEP = K * K - 1;

   state_t              r_state;
   state_t              w_nextState;
   logic [OPW-1:0]      r_a;
   logic [OPW-1:0]      r_b;
   logic [2*OPW-1:0]    r_acc;
   logic [STEP_W-1:0]   r_step;

   logic                w_accept;
   logic                w_lastStep;
   logic [STEP_W-1:0]   w_iIdx;
   logic [STEP_W-1:0]   w_jIdx;
   int                  w_aShift;
   int                  w_bShift;
   logic [CHUNK-1:0]    w_aChunk;
   logic [CHUNK-1:0]    w_bChunk;
   logic [2*CHUNK-1:0]  w_pp;
   logic [2*OPW-1:0]    w_ppAligned;

   // The step counter walks the multiplicand chunk fastest: i = s mod K
   // selects the chunk of a, j = s div K selects the chunk of b.
   assign w_iIdx     = r_step % STEP_W'(K);
   assign w_jIdx     = r_step / STEP_W'(K);
   assign w_aShift   = CHUNK * int'(w_iIdx);
   assign w_bShift   = CHUNK * int'(w_jIdx);
   assign w_aChunk   = CHUNK'(r_a >> w_aShift);
   assign w_bChunk   = CHUNK'(r_b >> w_bShift);
   assign w_lastStep = (r_step == STEP_W'(LAST_STEP));
   assign w_accept   = in_ready && in_valid;

   // The shared multiplier is combinational, so its partial product is
   // consumed in the same cycle the chunks are selected.
   multiplier_3bit u_mul3 (
      .i_a (w_aChunk),
      .i_b (w_bChunk),
      .o_p (w_pp)
   );

   // A partial product of chunks i and j carries weight 2^(3*(i+j)).
   assign w_ppAligned = (2*OPW)'(w_pp) << (w_aShift + w_bShift);

   // The accumulator doubles as the product register: it only changes in
   // IDLE-accept and RUN, so it is naturally held stable throughout DONE.
   assign product = r_acc;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake decode. Operands are only taken in IDLE, so a
   // result handshake in DONE can never coincide with a new accept.
   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_lastStep) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Operand capture, step counting and accumulation. Every one of the K*K
   // steps runs even for zero operands; there is no early exit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_step <= '0;
      end else if (w_accept) begin
         r_a    <= in_a;
         r_b    <= in_b;
         r_acc  <= '0;
         r_step <= '0;
      end else if (r_state == RUN) begin
         r_acc  <= r_acc + w_ppAligned;
         r_step <= r_step + 1'b1;
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

   localparam int OPW     = 6;
   localparam int K       = OPW / 3;
   localparam int LAT     = K * K + 1;
   localparam int SPACING = K * K + 2;
   localparam int OPW9    = 9;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              inValid = 1'b0;
   logic              inReady;
   logic [OPW-1:0]    inA = '0;
   logic [OPW-1:0]    inB = '0;
   logic              outValid;
   logic              outReady = 1'b1;
   logic [2*OPW-1:0]  product;
   logic              busy;

   logic              v9 = 1'b0;
   logic              ready9;
   logic [OPW9-1:0]   a9 = '0;
   logic [OPW9-1:0]   b9 = '0;
   logic              ov9;
   logic              or9 = 1'b1;
   logic [2*OPW9-1:0] p9;
   logic              busy9;

   typedef struct {
      logic [2*OPW-1:0] prod;
      int               acceptCyc;
   } exp_t;

   exp_t sbQ[$];
   int   checksPassed = 0;
   int   checksTotal  = 0;
   int   cyc = 0;
   int   lastAcceptCyc = -1000;
   bit   prevOV = 1'b0;
   bit   expectIdle = 1'b0;

   mult_seq_ctrl #(.OPW(OPW), .STEP_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_a      (inA),
      .in_b      (inB),
      .out_valid (outValid),
      .out_ready (outReady),
      .product   (product),
      .busy      (busy)
   );

   mult_seq_ctrl #(.OPW(OPW9), .STEP_W(4)) dut9 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v9),
      .in_ready  (ready9),
      .in_a      (a9),
      .in_b      (b9),
      .out_valid (ov9),
      .out_ready (or9),
      .product   (p9),
      .busy      (busy9)
   );

   // Free-running clock and a cycle counter used for latency/spacing checks.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Hard stop in case something wedges the main sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input longint unsigned act,
                              input longint unsigned exp);
      checksTotal++;
      if (act == exp) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Offer an operand pair (called at a negedge) and wait for the accept.
   // The reference result is plain arithmetic a*b pushed to the scoreboard.
   task automatic applyStimulus(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                input bit keepValid, input bit exactGap);
      int waited = 0;
      logic [2*OPW-1:0] expProd;
      inValid = 1'b1;
      inA     = a;
      inB     = b;
      while (!inReady && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!inReady) begin
         checkOutput("accept_timeout", 0, 1);
         inValid = 1'b0;
         return;
      end
      if (exactGap) begin
         checkOutput("accept_spacing", cyc - lastAcceptCyc, SPACING);
      end else begin
         checkOutput("accept_min_spacing", (cyc - lastAcceptCyc) >= SPACING, 1);
      end
      lastAcceptCyc = cyc;
      expProd = (2*OPW)'(a) * (2*OPW)'(b);
      sbQ.push_back('{prod: expProd, acceptCyc: cyc});
      @(negedge clk);
      if (!keepValid) begin
         inValid = 1'b0;
      end
   endtask

   task automatic waitDrain();
      int t = 0;
      while (sbQ.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (sbQ.size() != 0) begin
         checkOutput("drain_timeout", sbQ.size(), 0);
         sbQ.delete();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   // Monitor: whenever a product is presented, compare it with the head of
   // the scoreboard; pop on handshake and expect IDLE on the following cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (outValid) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpected_out_valid", 1, 0);
            end else begin
               if (!prevOV) begin
                  checkOutput("latency", cyc - sbQ[0].acceptCyc, LAT);
               end
               checkOutput("product", product, sbQ[0].prod);
               checkOutput("in_ready_in_done", inReady, 0);
               checkOutput("busy_in_done", busy, 1);
               if (outReady) begin
                  void'(sbQ.pop_front());
                  expectIdle = 1'b1;
               end
            end
         end else if (expectIdle) begin
            checkOutput("in_ready_after_handshake", inReady, 1);
            checkOutput("busy_after_handshake", busy, 0);
            expectIdle = 1'b0;
         end
         prevOV = outValid;
      end
   end

   initial begin
      logic [OPW-1:0] ra;
      logic [OPW-1:0] rb;
      int t;
      int startCyc;

      // Reset state of both instances.
      #12;
      checkOutput("rst_in_ready", inReady, 1);
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_product", product, 0);
      checkOutput("rst9_in_ready", ready9, 1);
      checkOutput("rst9_out_valid", ov9, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Max operands, then small and cross-chunk values.
      applyStimulus(6'd63, 6'd63, 1'b0, 1'b0);
      waitDrain();
      applyStimulus(6'd5, 6'd7, 1'b0, 1'b0);
      waitDrain();
      applyStimulus(6'd8, 6'd9, 1'b0, 1'b0);
      waitDrain();
      applyStimulus(6'd0, 6'd45, 1'b0, 1'b0);
      waitDrain();
      applyStimulus(6'd1, 6'd63, 1'b0, 1'b0);
      waitDrain();

      // Backpressure: hold out_ready low for 7 cycles once the result shows.
      outReady = 1'b0;
      applyStimulus(6'd12, 6'd10, 1'b0, 1'b0);
      t = 0;
      while (!outValid && t < 20) begin
         @(negedge clk);
         t++;
      end
      checkOutput("bp_out_valid_seen", outValid, 1);
      repeat (7) @(negedge clk);
      outReady = 1'b1;
      waitDrain();

      // Inputs ignored while busy: the second pair waits for IDLE.
      applyStimulus(6'd3, 6'd3, 1'b1, 1'b0);
      inA = 6'd63;
      inB = 6'd63;
      @(negedge clk);
      checkOutput("ignore_in_ready", inReady, 0);
      checkOutput("ignore_busy", busy, 1);
      applyStimulus(6'd63, 6'd63, 1'b0, 1'b1);
      waitDrain();

      // Asynchronous reset in the middle of RUN.
      applyStimulus(6'd40, 6'd50, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrun_rst_out_valid", outValid, 0);
      checkOutput("midrun_rst_busy", busy, 0);
      checkOutput("midrun_rst_in_ready", inReady, 1);
      sbQ.delete();
      prevOV        = 1'b0;
      expectIdle    = 1'b0;
      lastAcceptCyc = -1000;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(6'd2, 6'd3, 1'b0, 1'b0);
      waitDrain();

      // Back-to-back random pairs with in_valid held high.
      for (int i = 0; i < 5; i++) begin
         ra = 6'($urandom_range(0, 63));
         rb = 6'($urandom_range(0, 63));
         applyStimulus(ra, rb, i < 4, i > 0);
      end
      waitDrain();

      // Wider instance: OPW=9 needs 9 steps, so out_valid comes 10 cycles on.
      v9 = 1'b1;
      a9 = 9'd511;
      b9 = 9'd511;
      checkOutput("opw9_in_ready", ready9, 1);
      startCyc = cyc;
      @(negedge clk);
      v9 = 1'b0;
      t = 0;
      while (!ov9 && t < 40) begin
         @(negedge clk);
         t++;
      end
      checkOutput("opw9_latency", cyc - startCyc, 10);
      checkOutput("opw9_product", p9, 261121);
      @(negedge clk);
      checkOutput("opw9_idle_after", ready9, 1);

      $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
